// File: rtl/led_duty_sequencer.sv
// Breathing duty sequencer: PWM frame timebase plus a rise/hold/fall/hold master level.
// Optional chase across channels when LED_DUTY_CHASE_EN is defined.
module led_duty_sequencer #(
   parameter int unsigned NUM_CH     = 5,
   parameter int unsigned DUTY_W     = 8,
   parameter int unsigned PERIOD     = 120,
   parameter int unsigned STEP       = 4,
   parameter int unsigned UPDATE_DIV = 4,
   parameter int unsigned HOLD_UPD   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   output logic                       frame_tick,
   output logic [NUM_CH*DUTY_W-1:0]   duty,
   output logic                       duty_valid
);

   localparam int unsigned LVL_W  = DUTY_W + 1;
   localparam int unsigned DIV_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_UPD + 1);

   localparam logic [DUTY_W-1:0] CNT_MAX  = DUTY_W'(PERIOD);
   localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(PERIOD);
   localparam logic [LVL_W-1:0]  LVL_STEP = LVL_W'(STEP);
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(UPDATE_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_UPD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RISE,
      ST_HOLD_HI,
      ST_FALL,
      ST_HOLD_LO
   } state_t;

   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              frame_tick_q, frame_tick_d;
   logic              duty_valid_q, duty_valid_d;
   state_t            state_q, state_d;
   logic [LVL_W-1:0]  lvl_q, lvl_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic              upd_c;
   logic [LVL_W-1:0]  lvl_sum_c;
   logic [LVL_W-1:0]  lvl_diff_c;
   logic [HOLD_W-1:0] hold_inc_c;

   // Frame timebase; frame_tick is pre-decoded so it lines up with cnt == PERIOD
   always_comb begin
      cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      frame_tick_d = (cnt_d == CNT_MAX);
      div_d        = div_q;
      if (frame_tick_q) begin
         div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      end
   end

   assign upd_c      = frame_tick_q && (div_q == DIV_MAX);
   assign lvl_sum_c  = lvl_q + LVL_STEP;
   assign lvl_diff_c = lvl_q - LVL_STEP;
   assign hold_inc_c = hold_q + 1'b1;

   // Breathing state machine; everything moves only at update points
   always_comb begin
      state_d      = state_q;
      lvl_d        = lvl_q;
      hold_d       = hold_q;
      duty_valid_d = upd_c;
      if (upd_c) begin
         if (!en) begin
            state_d = ST_IDLE;
            lvl_d   = '0;
            hold_d  = '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (LVL_STEP >= LVL_MAX) begin
                     lvl_d   = LVL_MAX;
                     state_d = ST_HOLD_HI;
                     hold_d  = '0;
                  end else begin
                     lvl_d   = LVL_STEP;
                     state_d = ST_RISE;
                  end
               end
               ST_RISE: begin
                  if (lvl_sum_c >= LVL_MAX) begin
                     lvl_d   = LVL_MAX;
                     state_d = ST_HOLD_HI;
                     hold_d  = '0;
                  end else begin
                     lvl_d = lvl_sum_c;
                  end
               end
               ST_HOLD_HI: begin
                  hold_d = hold_inc_c;
                  if (hold_inc_c == HOLD_END) begin
                     state_d = ST_FALL;
                     hold_d  = '0;
                  end
               end
               ST_FALL: begin
                  if (lvl_q <= LVL_STEP) begin
                     lvl_d   = '0;
                     state_d = ST_HOLD_LO;
                     hold_d  = '0;
                  end else begin
                     lvl_d = lvl_diff_c;
                  end
               end
               ST_HOLD_LO: begin
                  hold_d = hold_inc_c;
                  if (hold_inc_c == HOLD_END) begin
                     state_d = ST_RISE;
                     hold_d  = '0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  lvl_d   = '0;
                  hold_d  = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         div_q        <= '0;
         frame_tick_q <= 1'b0;
         duty_valid_q <= 1'b0;
         state_q      <= ST_IDLE;
         lvl_q        <= '0;
         hold_q       <= '0;
      end else begin
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         frame_tick_q <= frame_tick_d;
         duty_valid_q <= duty_valid_d;
         state_q      <= state_d;
         lvl_q        <= lvl_d;
         hold_q       <= hold_d;
      end
   end

   assign frame_tick = frame_tick_q;
   assign duty_valid = duty_valid_q;

`ifdef LED_DUTY_CHASE_EN
   logic [DUTY_W-1:0] duty_q [NUM_CH];
   logic [DUTY_W-1:0] duty_d [NUM_CH];

   // Comet tail: channel 0 takes the new level, the rest shift one place outward
   always_comb begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
         duty_d[i] = duty_q[i];
      end
      if (upd_c) begin
         if (!en) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
               duty_d[i] = '0;
            end
         end else begin
            duty_d[0] = lvl_d[DUTY_W-1:0];
            for (int i = 1; i < int'(NUM_CH); i++) begin
               duty_d[i] = duty_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q <= '{default: '0};
      end else begin
         duty_q <= duty_d;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
         duty[i*DUTY_W +: DUTY_W] = duty_q[i];
      end
   end
`else
   // Without chase every channel is the master level, which is already a register
   assign duty = {NUM_CH{lvl_q[DUTY_W-1:0]}};
`endif

endmodule

// File: tb/tb_led_duty_sequencer.sv
// Bench for led_duty_sequencer: two instances (UPDATE_DIV 1 and 3) against a time-based model.
module tb_led_duty_sequencer;

   localparam int P  = 120;
   localparam int ST = 40;
   localparam int HU = 2;
   localparam int NC = 5;
   localparam int DW = 8;
   localparam int FR = P + 1;

   localparam int PH_IDLE = 0;
   localparam int PH_RISE = 1;
   localparam int PH_HI   = 2;
   localparam int PH_FALL = 3;
   localparam int PH_LO   = 4;

`ifdef LED_DUTY_CHASE_EN
   localparam logic [NC*DW-1:0] EXP3 = {8'd0, 8'd0, 8'd40, 8'd80, 8'd120};
`else
   localparam logic [NC*DW-1:0] EXP3 = {5{8'd120}};
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic ft1, dv1, ft3, dv3;
   logic [NC*DW-1:0] duty1, duty3;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_l [11] = '{40, 80, 120, 120, 120, 80, 40, 0, 0, 0, 40};

   always #5 clk = ~clk;

   led_duty_sequencer #(.NUM_CH(NC), .DUTY_W(DW), .PERIOD(P), .STEP(ST),
                        .UPDATE_DIV(1), .HOLD_UPD(HU)) u_dut1 (
      .clk(clk), .rst(rst), .en(en),
      .frame_tick(ft1), .duty(duty1), .duty_valid(dv1));

   led_duty_sequencer #(.NUM_CH(NC), .DUTY_W(DW), .PERIOD(P), .STEP(ST),
                        .UPDATE_DIV(3), .HOLD_UPD(HU)) u_dut3 (
      .clk(clk), .rst(rst), .en(en),
      .frame_tick(ft3), .duty(duty3), .duty_valid(dv3));

   // Model: t = cycles since reset release; updates fall on fixed multiples of the frame
   typedef struct {
      int               t;
      int               lvl;
      int               ph;
      int               hold;
      logic [NC*DW-1:0] duty;
      logic             valid;
   } mdl_t;

   mdl_t m1, m3;
   bit   cur_v1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.t     = 0;
      m.lvl   = 0;
      m.ph    = PH_IDLE;
      m.hold  = 0;
      m.duty  = '0;
      m.valid = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t mi, input bit e, input int div);
      mdl_t m;
      bit   upd;
      int   base;
      m   = mi;
      upd = (m.t % (FR * div)) == (FR * div - 1);
      m.valid = upd;
      m.t     = m.t + 1;
      if (upd) begin
         if (!e) begin
            m.ph   = PH_IDLE;
            m.lvl  = 0;
            m.hold = 0;
            m.duty = '0;
         end else begin
            case (m.ph)
               PH_IDLE, PH_RISE: begin
                  base = (m.ph == PH_IDLE) ? 0 : m.lvl;
                  if (base + ST >= P) begin
                     m.lvl  = P;
                     m.ph   = PH_HI;
                     m.hold = 0;
                  end else begin
                     m.lvl = base + ST;
                     m.ph  = PH_RISE;
                  end
               end
               PH_HI: begin
                  m.hold++;
                  if (m.hold == HU) m.ph = PH_FALL;
               end
               PH_FALL: begin
                  if (m.lvl <= ST) begin
                     m.lvl  = 0;
                     m.ph   = PH_LO;
                     m.hold = 0;
                  end else begin
                     m.lvl = m.lvl - ST;
                  end
               end
               default: begin
                  m.hold++;
                  if (m.hold == HU) m.ph = PH_RISE;
               end
            endcase
`ifdef LED_DUTY_CHASE_EN
            m.duty = {m.duty[NC*DW-DW-1:0], DW'(m.lvl)};
`else
            m.duty = {NC{DW'(m.lvl)}};
`endif
         end
      end
      return m;
   endfunction

   // One clock: drive at negedge, check this cycle, then advance the model across the posedge
   task automatic do_cycle(input bit r, input bit e);
      @(negedge clk);
      rst = r;
      en  = e;
      if (r) begin
         m1 = mdl_reset();
         m3 = mdl_reset();
      end
      #1;
      chk("ft1",   ft1,   (m1.t % FR) == P);
      chk("dv1",   dv1,   m1.valid);
      chk("duty1", duty1, m1.duty);
      chk("ft3",   ft3,   (m3.t % FR) == P);
      chk("dv3",   dv3,   m3.valid);
      chk("duty3", duty3, m3.duty);
      cur_v1 = m1.valid;
      if (!r) begin
         m1 = mdl_step(m1, e, 1);
         m3 = mdl_step(m3, e, 3);
      end
   endtask

   task automatic wait_strobe(input bit e, input string tag);
      int n;
      n = 0;
      do begin
         do_cycle(1'b0, e);
         n++;
      end while (!cur_v1 && n < 4 * FR);
      chk({"strobe_", tag}, cur_v1, 1);
   endtask

   initial begin
      int  n;
      int  rst_left;
      bit  e;

      // Reset, then idle with en low
      repeat (4) do_cycle(1'b1, 1'b0);
      repeat (3) wait_strobe(1'b0, "idle");
      chk("idle_duty", duty1, 0);

      // Full breathing sequence from release with en high
      repeat (2) do_cycle(1'b1, 1'b1);
      for (int k = 0; k < 11; k++) begin
         wait_strobe(1'b1, "seq");
         chk("lseq", duty1[DW-1:0], exp_l[k]);
         if (k == 2) chk("upd3_duty", duty1, EXP3);
      end

      // en dropped mid-RISE between updates
      repeat (2) do_cycle(1'b1, 1'b1);
      wait_strobe(1'b1, "r1");
      wait_strobe(1'b1, "r2");
      chk("rise80", duty1[DW-1:0], 80);
      repeat (50) do_cycle(1'b0, 1'b1);
      do_cycle(1'b0, 1'b0);
      chk("drop_hold", duty1[DW-1:0], 80);
      wait_strobe(1'b0, "drop");
      chk("drop_clear", duty1, 0);
      wait_strobe(1'b1, "reraise");
      chk("reraise40", duty1[DW-1:0], 40);

      // Reset mid-frame during HOLD_HI
      repeat (2) do_cycle(1'b1, 1'b1);
      repeat (4) wait_strobe(1'b1, "hh");
      chk("hold_hi", duty1[DW-1:0], 120);
      repeat (30) do_cycle(1'b0, 1'b1);
      do_cycle(1'b1, 1'b1);
      chk("rst_async", {ft1, dv1, duty1}, 0);
      do_cycle(1'b1, 1'b1);
      n = 0;
      do begin
         do_cycle(1'b0, 1'b1);
         n++;
      end while (!ft1 && n < 3 * FR);
      chk("first_ft", n, FR);
      wait_strobe(1'b1, "restart");
      chk("restart40", duty1[DW-1:0], 40);

      // Random en toggling with occasional reset pulses
      e        = 1'b1;
      rst_left = 0;
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 199) == 0) e = ~e;
         if (rst_left == 0 && $urandom_range(0, 2999) == 0) rst_left = int'($urandom_range(1, 5));
         do_cycle(rst_left > 0, e);
         if (rst_left > 0) rst_left--;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_duty_sequencer.md
# led_duty_sequencer

Upstream stage of the LED PWM driver: generates per-channel duty values that ramp ("breathe") up and down over time, plus the PWM frame timing the downstream comparator stage consumes. Runs a free-running period counter matching the PWM frame, steps a master brightness level through a rise/hold/fall/hold state machine, and optionally chases that level across channels. Duty updates are issued only at frame boundaries, so the PWM stage never sees a mid-frame change.

## Interface
- NUM_CH, 5, number of LED channels
- DUTY_W, 8, duty/counter width; requires PERIOD < 2^DUTY_W
- PERIOD, 120, final period-counter value; frame = PERIOD+1 cycles; duty range 0..PERIOD
- STEP, 4, level increment/decrement per update; 1 ≤ STEP ≤ PERIOD
- UPDATE_DIV, 4, frames per sequencer update; ≥ 1
- HOLD_UPD, 8, updates spent in each hold state; ≥ 1

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  breathing enable; sampled only at update points
- frame_tick  out  1  high for the one cycle in which the period counter equals PERIOD
- duty  out  NUM_CH*DUTY_W  duty values; channel i in bits [i*DUTY_W +: DUTY_W]
- duty_valid  out  1  one-cycle strobe; duty changed or was reissued at this edge

## Operation
- Period counter cnt: 0..PERIOD, +1 per cycle, wraps PERIOD→0; runs whenever rst low, independent of en.
- Frame divider div: counts frame_ticks 0..UPDATE_DIV-1. Update point = clock edge ending a cycle where frame_tick=1 and div=UPDATE_DIV-1; div wraps to 0 there.
- All state below changes only at update points; duty_valid=1 in the cycle after every update point (also when en=0).
- Master level L (DUTY_W+1-bit arithmetic, no wrap). FSM states:
  - IDLE: if en, → RISE, L=STEP (saturate at PERIOD; if saturated → HOLD_HI). Else L=0.
  - RISE: if L+STEP ≥ PERIOD: L=PERIOD, → HOLD_HI, hold_cnt=0; else L+=STEP.
  - HOLD_HI: hold_cnt+=1, L unchanged; when new hold_cnt=HOLD_UPD → FALL.
  - FALL: if L ≤ STEP: L=0, → HOLD_LO, hold_cnt=0; else L-=STEP.
  - HOLD_LO: as HOLD_HI, exits → RISE.
  - Any state with en=0 at update point: → IDLE, L=0, all duty channels cleared to 0 (no shift), hold_cnt=0.
- duty assignment at update (en=1): see Configuration. Channel 0 always gets new L.
- Reset values: cnt=0, div=0, hold_cnt=0, state IDLE, L=0, duty all 0, duty_valid=0, frame_tick=0.

## Timing
- frame_tick decoded from registered cnt; no combinational path from en.
- duty and duty_valid registered; update latency = 1 edge after the frame_tick cycle, so duty_valid is high during the cnt=0 cycle of the new frame. Downstream latches duty on duty_valid.
- duty_valid period: (PERIOD+1)*UPDATE_DIV cycles.
- en change between update points has no effect until the next update point.
- rst mid-operation: all outputs/state to reset values immediately; after release, first frame_tick occurs in the cycle where cnt=PERIOD (PERIOD+1th cycle from release).

## Configuration
- LED_DUTY_CHASE_EN defined: at each enabled update, duty[0]=new L, duty[i]=previous duty[i-1] for i=1..NUM_CH-1 (comet/chase effect).
- Undefined: all channels take new L at every update; no shift register inferred.

## Test plan
(PERIOD=120, STEP=40, UPDATE_DIV=1, HOLD_UPD=2, NUM_CH=5, chase enabled unless noted.)
- Reset held then released, en=0 -> all outputs 0 during reset; duty_valid every 121 cycles, duty all 0, frame_tick one cycle before each strobe.
- en=1 from release -> L sequence per update: 40,80,120,120,120,80,40,0,0,0,40; after update 3 duty ch0..ch4 = 120,80,40,0,0.
- Same as above without LED_DUTY_CHASE_EN -> all five channels equal L at every update.
- UPDATE_DIV=3 -> duty_valid spacing 363 cycles; level changes only at those strobes.
- en dropped mid-RISE (L=80) between updates -> no change until next update, then duty all 0, state IDLE; en re-raised -> next update L=40.
- rst asserted mid-frame during HOLD_HI -> duty, duty_valid, frame_tick 0 asynchronously; after release first frame_tick on the 121st cycle, sequence restarts from IDLE.
